// File: rtl/ddr3_mem_pkg.sv
// Shared types and widths for the DDR3 request arbiter slice.
package ddr3_mem_pkg;

    typedef enum logic [1:0] {ARB, ISSUE, REF} arb_state_t;

    localparam logic CMD_READ  = 1'b1;
    localparam logic CMD_WRITE = 1'b0;

    localparam int DDR3_BA_W    = 3;
    localparam int DDR3_ADDR_W  = 15;
    localparam int DDR3_BURST_W = 64;

    typedef struct packed {
        logic                    cmd;
        logic [DDR3_BA_W-1:0]    ba;
        logic [DDR3_ADDR_W-1:0]  addr;
        logic [DDR3_BURST_W-1:0] wdata;
    } ddr3_cmd_t;

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Refresh interval counter with saturating postponed-refresh count and sticky overflow.
module ddr3_refresh_timer
    import ddr3_mem_pkg::*;
#(
    parameter int TREFI_CYC    = 7800,
    parameter int REF_MAX_POST = 8
) (
    input  logic       cpu_clk,
    input  logic       RESET_N,
    input  logic       ref_done,
    output logic [3:0] pending,
    output logic       overflow
);

    localparam int CNT_W = $clog2(TREFI_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             tick;

    assign tick = (cnt_q == CNT_W'(TREFI_CYC - 1));

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        // A tick and a completed refresh in the same cycle cancel out.
        if (tick && !ref_done) begin
            if (pend_q != 4'(REF_MAX_POST)) pend_d = pend_q + 4'd1;
        end else if (!tick && ref_done && pend_q != 4'd0) begin
            pend_d = pend_q - 4'd1;
        end
        if (tick && pend_q == 4'(REF_MAX_POST)) ovf_d = 1'b1;
    end

    always_ff @(posedge cpu_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q  <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/ddr3_req_arbiter.sv
// Round-robin command arbiter in front of the DDR3 controller, with refresh scheduling
// enabled by defining DDR3_ARB_REFRESH_EN.
module ddr3_req_arbiter
    import ddr3_mem_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int TREFI_CYC    = 7800,
    parameter int REF_MAX_POST = 8
) (
    input  logic                                      cpu_clk,
    input  logic                                      RESET_N,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ-1:0]                        req_cmd,
    input  logic [NUM_REQ-1:0][DDR3_BA_W-1:0]         req_ba,
    input  logic [NUM_REQ-1:0][DDR3_ADDR_W-1:0]       req_addr,
    input  logic [NUM_REQ-1:0][DDR3_BURST_W-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]                        req_gnt,
    output logic                                      cont_valid,
    output logic                                      cont_cmd,
    output logic [DDR3_BA_W-1:0]                      cont_ba,
    output logic [DDR3_ADDR_W-1:0]                    cont_addr,
    output logic [DDR3_BURST_W-1:0]                   cont_wdata,
    input  logic                                      cont_rdy,
    output logic                                      ref_req,
    input  logic                                      ref_ack,
    output logic [3:0]                                ref_pending,
    output logic                                      ref_overflow
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d, win_q, win_d, win_c;
    ddr3_cmd_t          cmd_q, cmd_d;
    logic               vld_q, vld_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               ref_full, ref_any;

    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && vld[idx]) begin
                win   = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign win_c = rr_pick(req_valid, ptr_q);

`ifdef DDR3_ARB_REFRESH_EN
    logic ref_done;
    assign ref_done = (state_q == REF) && ref_ack;
    assign ref_req  = (state_q == REF);

    ddr3_refresh_timer #(
        .TREFI_CYC    (TREFI_CYC),
        .REF_MAX_POST (REF_MAX_POST)
    ) u_ref_timer (
        .cpu_clk  (cpu_clk),
        .RESET_N  (RESET_N),
        .ref_done (ref_done),
        .pending  (ref_pending),
        .overflow (ref_overflow)
    );
`else
    assign ref_req      = 1'b0;
    assign ref_pending  = 4'd0;
    assign ref_overflow = 1'b0;
`endif

    assign ref_full = (ref_pending == 4'(REF_MAX_POST));
    assign ref_any  = |ref_pending;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        vld_d   = vld_q;
        gnt_d   = '0;
        case (state_q)
            ARB: begin
                // Skip the cycle the grant pulse is out: the winner's req_valid is still high.
                if (gnt_q == '0) begin
                    if (ref_full) begin
                        state_d = REF;
                    end else if (|req_valid) begin
                        win_d   = win_c;
                        cmd_d   = '{cmd:   req_cmd[win_c],   ba:    req_ba[win_c],
                                    addr:  req_addr[win_c],  wdata: req_wdata[win_c]};
                        vld_d   = 1'b1;
                        state_d = ISSUE;
                    end else if (ref_any) begin
                        state_d = REF;
                    end
                end
            end
            ISSUE: begin
                if (vld_q && cont_rdy) begin
                    gnt_d[win_q] = 1'b1;
                    vld_d        = 1'b0;
                    ptr_d        = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                    state_d      = ARB;
                end
            end
            REF: begin
                if (ref_ack) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ARB;
            ptr_q   <= '0;
            win_q   <= '0;
            cmd_q   <= '0;
            vld_q   <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            gnt_q   <= gnt_d;
        end
    end

    assign req_gnt    = gnt_q;
    assign cont_valid = vld_q;
    assign cont_cmd   = cmd_q.cmd;
    assign cont_ba    = cmd_q.ba;
    assign cont_addr  = cmd_q.addr;
    assign cont_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Directed checks of arbitration order, staging hold, reset drop and refresh behaviour.
module tb_ddr3_req_arbiter;
    import ddr3_mem_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           req_valid, req_cmd, req_gnt;
    logic [3:0][2:0]      req_ba;
    logic [3:0][14:0]     req_addr;
    logic [3:0][63:0]     req_wdata;
    logic                 cont_valid, cont_cmd, cont_rdy;
    logic [2:0]           cont_ba;
    logic [14:0]          cont_addr;
    logic [63:0]          cont_wdata;
    logic                 ref_req, ref_ack, ref_overflow;
    logic [3:0]           ref_pending;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ddr3_req_arbiter #(.NUM_REQ(4), .TREFI_CYC(16), .REF_MAX_POST(8)) dut (
        .cpu_clk(clk), .RESET_N(rst_n),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_ba(req_ba),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt),
        .cont_valid(cont_valid), .cont_cmd(cont_cmd), .cont_ba(cont_ba),
        .cont_addr(cont_addr), .cont_wdata(cont_wdata), .cont_rdy(cont_rdy),
        .ref_req(ref_req), .ref_ack(ref_ack), .ref_pending(ref_pending),
        .ref_overflow(ref_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input int max, output logic [3:0] g, output int gap);
        g   = '0;
        gap = 0;
        while (g == '0 && gap < max) begin
            @(negedge clk);
            gap++;
            g = req_gnt;
        end
        if (g == '0) chk("gnt_timeout", 64'(g), 64'hf);
    endtask

    task automatic wait_sig(input string tag, input int max, input int which);
        int n = 0;
        logic s = 1'b0;
        while (!s && n < max) begin
            @(negedge clk);
            n++;
            s = (which == 0) ? cont_valid : (which == 1) ? ref_req : ref_overflow;
        end
        chk(tag, 64'(s), 64'd1);
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] e;
        int         gap;
        int         order[5] = '{0, 1, 2, 3, 0};
        int         ngnt;

        req_valid = '0; req_cmd = '0; req_ba = '0; req_addr = '0; req_wdata = '0;
        cont_rdy  = 1'b0; ref_ack = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        do_reset();
        chk("rst_state", {req_gnt, cont_valid, ref_req, ref_pending, ref_overflow}, 64'd0);

        // 1: single read from requester 2
        req_valid = 4'b0100; req_cmd = 4'b0100; req_addr[2] = 15'h0123; req_ba[2] = 3'd6;
        repeat (2) @(negedge clk);
        chk("t1_valid", 64'(cont_valid), 64'd1);
        chk("t1_addr",  64'(cont_addr),  64'h0123);
        chk("t1_cmd_ba", {cont_cmd, cont_ba}, {CMD_READ, 3'd6});
        chk("t1_nognt", 64'(req_gnt), 64'd0);
        cont_rdy = 1'b1;
        @(negedge clk);
        chk("t1_gnt", 64'(req_gnt), 64'b0100);
        chk("t1_vld_drop", 64'(cont_valid), 64'd0);
        req_valid = '0;
        @(negedge clk);
        chk("t1_gnt_pulse", 64'(req_gnt), 64'd0);

        // 2: all four requesting, round-robin from 0
        do_reset();
        for (int i = 0; i < 4; i++) req_addr[i] = 15'(16'h0100 + i);
        req_cmd = 4'b0000; req_valid = 4'b1111; cont_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(20, g, gap);
            e = 4'(1 << order[k]);
            chk("t2_gnt", 64'(g), 64'(e));
            if (k > 0) chk("t2_gap", 64'(gap + 1 >= 3), 64'd1);
            if (k == 4) begin
                req_valid = '0;
                cont_rdy  = 1'b0;
            end
            @(negedge clk);
            chk("t2_pulse", 64'(req_gnt), 64'd0);
        end
`ifndef DDR3_ARB_REFRESH_EN
        chk("t2_ref_tied", {ref_req, ref_pending, ref_overflow}, 64'd0);
`endif

        // 3: staged write held while controller is not ready
        req_valid = 4'b0010; req_cmd = 4'b0000; req_ba[1] = 3'd5;
        req_addr[1] = 15'h7fff; req_wdata[1] = 64'hDEADBEEF_CAFEF00D;
        wait_sig("t3_valid", 10, 0);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_data", cont_wdata, 64'hDEADBEEF_CAFEF00D);
            chk("t3_hold_ctl", {cont_valid, cont_cmd, cont_ba, cont_addr},
                {1'b1, CMD_WRITE, 3'd5, 15'h7fff});
            chk("t3_nognt", 64'(req_gnt), 64'd0);
            @(negedge clk);
        end
        cont_rdy = 1'b1;
        @(negedge clk);
        chk("t3_gnt", 64'(req_gnt), 64'b0010);
        req_valid = '0; cont_rdy = 1'b0;
        @(negedge clk);

        // 6: reset during ISSUE drops the command; pointer restarts at 0
        req_valid = 4'b1111;
        wait_sig("t6_valid", 10, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_clr", {cont_valid, req_gnt}, 64'd0);
        cont_rdy = 1'b1;
        ngnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (req_gnt != '0) ngnt++;
        end
        chk("t6_no_gnt", 64'(ngnt), 64'd0);
        rst_n = 1'b1;
        wait_gnt(20, g, gap);
        chk("t6_first_gnt", 64'(g), 64'b0001);
        req_valid = '0; cont_rdy = 1'b0;

`ifdef DDR3_ARB_REFRESH_EN
        // 4: opportunistic refresh with no requests
        do_reset();
        wait_sig("t4_ref_req", 40, 1);
        chk("t4_pend1", 64'(ref_pending), 64'd1);
        ref_ack = 1'b1;
        @(negedge clk);
        ref_ack = 1'b0;
        chk("t4_pend0", {ref_req, ref_pending}, 64'd0);

        // 5: continuous traffic, refresh never acknowledged
        do_reset();
        req_valid = 4'b1111; cont_rdy = 1'b1;
        wait_sig("t5_ref_req", 200, 1);
        chk("t5_pend_max", 64'(ref_pending), 64'd8);
        chk("t5_no_ovf", 64'(ref_overflow), 64'd0);
        ngnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_gnt != '0) ngnt++;
        end
        chk("t5_ref_blocks", 64'(ngnt), 64'd0);
        wait_sig("t5_overflow", 40, 2);
        req_valid = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
